// File: rtl/bcd_adder.sv
// Registered packed-BCD adder: DIGITS-wide ripple of per-digit decimal adders, one-cycle latency.
// Optional input-digit range detection on err is built only when BCD_ADDER_ERR_EN is defined.
module bcd_adder #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   s,
    output logic                  c,
    output logic                  err
);

    logic [4*DIGITS-1:0] w_sum;
    logic                w_cout;

    // Each digit lives in its own scope so the carry chain is a set of
    // distinct nets rather than one self-referencing vector.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic       w_cin_d;
        logic       w_cout_d;
        logic [4:0] w_z;
        logic [4:0] w_adj;

        if (gi == 0) begin : g_first
            assign w_cin_d = cin;
        end else begin : g_next
            assign w_cin_d = g_digit[gi-1].w_cout_d;
        end

        assign w_z      = {1'b0, a[4*gi +: 4]} + {1'b0, b[4*gi +: 4]} + {4'b0000, w_cin_d};
        assign w_cout_d = (w_z > 5'd9);
        assign w_adj    = w_z + 5'd6;
        assign w_sum[4*gi +: 4] = w_cout_d ? w_adj[3:0] : w_z[3:0];
    end

    assign w_cout = g_digit[DIGITS-1].w_cout_d;

    logic                r_out_valid;
    logic [4*DIGITS-1:0] r_s;
    logic                r_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_c         <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s <= w_sum;
                r_c <= w_cout;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign c         = r_c;

`ifdef BCD_ADDER_ERR_EN
    logic [DIGITS-1:0] w_bad;
    logic              r_err;

    for (genvar gj = 0; gj < DIGITS; gj++) begin : g_range
        assign w_bad[gj] = (a[4*gj +: 4] > 4'd9) || (b[4*gj +: 4] > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (in_valid) begin
            r_err <= |w_bad;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// Self-checking bench for bcd_adder: one-digit and four-digit instances against a decimal reference model.
// Expected err follows BCD_ADDER_ERR_EN so the bench suits either build.
module tb_bcd_adder;

    logic        clk;
    logic        rst_n;

    logic        v1, ci1;
    logic [3:0]  a1, b1;
    logic        ov1, c1, e1;
    logic [3:0]  s1;

    logic        v4, ci4;
    logic [15:0] a4, b4;
    logic        ov4, c4, e4;
    logic [15:0] s4;

    bcd_adder #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(ci1),
        .out_valid(ov1), .s(s1), .c(c1), .err(e1)
    );

    bcd_adder #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .s(s4), .c(c4), .err(e4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        x1_v, x1_c, x1_e;
    logic [3:0]  x1_s;
    logic        x4_v, x4_c, x4_e;
    logic [15:0] x4_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal reference: digit-by-digit schoolbook addition with a carry of ten.
    function automatic void bcd_model(input logic [31:0] x, input logic [31:0] y, input logic ci,
                                      input int nd, output logic [31:0] sum,
                                      output logic co, output logic er);
        int k;
        k   = ci ? 1 : 0;
        sum = '0;
        er  = 1'b0;
        for (int i = 0; i < nd; i++) begin
            int dx, dy, z, d;
            dx = int'((x >> (4*i)) & 32'hF);
            dy = int'((y >> (4*i)) & 32'hF);
            if (dx > 9 || dy > 9) er = 1'b1;
            z = dx + dy + k;
            if (z >= 10) begin
                d = (z + 6) % 16;
                k = 1;
            end else begin
                d = z;
                k = 0;
            end
            sum = sum | (32'(d) << (4*i));
        end
        co = (k == 1);
`ifndef BCD_ADDER_ERR_EN
        er = 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".v1"}, {31'd0, ov1}, {31'd0, x1_v});
        check({tag, ".s1"}, {28'd0, s1},  {28'd0, x1_s});
        check({tag, ".c1"}, {31'd0, c1},  {31'd0, x1_c});
        check({tag, ".e1"}, {31'd0, e1},  {31'd0, x1_e});
        check({tag, ".v4"}, {31'd0, ov4}, {31'd0, x4_v});
        check({tag, ".s4"}, {16'd0, s4},  {16'd0, x4_s});
        check({tag, ".c4"}, {31'd0, c4},  {31'd0, x4_c});
        check({tag, ".e4"}, {31'd0, e4},  {31'd0, x4_e});
    endtask

    // Called just after a falling edge: drive, let one rising edge pass, check on the next falling edge.
    task automatic step(input string tag,
                        input logic nv1, input logic [3:0]  na1, input logic [3:0]  nb1, input logic nc1,
                        input logic nv4, input logic [15:0] na4, input logic [15:0] nb4, input logic nc4);
        logic [31:0] ms;
        logic        mc, me;
        v1 = nv1; a1 = na1; b1 = nb1; ci1 = nc1;
        v4 = nv4; a4 = na4; b4 = nb4; ci4 = nc4;
        x1_v = nv1;
        if (nv1) begin
            bcd_model({28'd0, na1}, {28'd0, nb1}, nc1, 1, ms, mc, me);
            x1_s = ms[3:0]; x1_c = mc; x1_e = me;
        end
        x4_v = nv4;
        if (nv4) begin
            bcd_model({16'd0, na4}, {16'd0, nb4}, nc4, 4, ms, mc, me);
            x4_s = ms[15:0]; x4_c = mc; x4_e = me;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [3:0] rnd_digit();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    function automatic logic [15:0] rnd_word();
        return {rnd_digit(), rnd_digit(), rnd_digit(), rnd_digit()};
    endfunction

    initial begin
        rst_n = 1'b0;
        v1 = 0; a1 = 0; b1 = 0; ci1 = 0;
        v4 = 0; a4 = 0; b4 = 0; ci4 = 0;
        x1_v = 0; x1_s = 0; x1_c = 0; x1_e = 0;
        x4_v = 0; x4_s = 0; x4_c = 0; x4_e = 0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Single-digit sweep over every nibble, cin=0; four-digit lane gets a=b=nnnn.
        for (int n = 0; n < 16; n++)
            step("sweep", 1'b1, 4'(n), 4'(n), 1'b0, 1'b1, {4{4'(n)}}, {4{4'(n)}}, 1'b0);

        // Carry-in corners and four-digit ripple.
        step("cin99", 1'b1, 4'd9, 4'd9, 1'b1, 1'b1, 16'h9999, 16'h0001, 1'b0);
        check("lit.s9", {28'd0, s1}, 32'd9);
        check("lit.9999", {16'd0, s4}, 32'h0000);
        check("lit.c4", {31'd0, c4}, 32'd1);
        step("cin00", 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b0);
        check("lit.s1", {28'd0, s1}, 32'd1);
        check("lit.6912", {16'd0, s4}, 32'h6912);
        step("cin4", 1'b1, 4'd5, 4'd4, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b1);

        // Handshake: two back-to-back accepts then idle; results hold while idle.
        step("hs1", 1'b1, 4'd3, 4'd4, 1'b0, 1'b1, 16'h0456, 16'h0544, 1'b0);
        step("hs2", 1'b1, 4'd8, 4'd7, 1'b0, 1'b1, 16'h5000, 16'h5000, 1'b1);
        step("hs3", 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 16'h1111, 16'h1111, 1'b0);
        step("hs4", 1'b0, 4'd2, 4'd2, 1'b1, 1'b0, 16'h2222, 16'h2222, 1'b1);
        step("hs5", 1'b1, 4'd14, 4'd2, 1'b0, 1'b1, 16'h00A0, 16'h0003, 1'b0);
        step("hs6", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // Random mix of valid/idle cycles and mostly-BCD operands.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), rnd_digit(), rnd_digit(), 1'($urandom),
                         1'($urandom_range(0, 3) != 0), rnd_word(), rnd_word(), 1'($urandom));

        // Asynchronous reset mid-cycle with nonzero outputs pending.
        step("pre_rst", 1'b1, 4'd9, 4'd9, 1'b1, 1'b1, 16'h9999, 16'h9999, 1'b1);
        v1 = 1'b1; a1 = 4'd12; b1 = 4'd12;
        v4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        x1_v = 0; x1_s = 0; x1_c = 0; x1_e = 0;
        x4_v = 0; x4_s = 0; x4_c = 0; x4_e = 0;
        check_all("async_rst");
        @(posedge clk);
        #1 check_all("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 4'd7, 4'd6, 1'b0, 1'b1, 16'h0999, 16'h0001, 1'b1);
        step("post_idle", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_adder.md
Name: bcd_adder

Overview:
Registered packed-BCD adder. Adds two DIGITS-wide BCD operands plus a carry-in and produces a BCD sum and a decimal carry-out, one clock after an accepted input. Used as the decimal arithmetic primitive in datapaths; the default single-digit instance replaces the former combinational bcdadder.

Parameters:
DIGITS, 1, number of BCD digits per operand (1..8); operand width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies a, b, cin this cycle
a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  decimal carry into digit 0
out_valid  output  1  s/c/err hold a new result this cycle
s  output  4*DIGITS  packed BCD sum
c  output  1  decimal carry out of the most significant digit
err  output  1  at least one input digit was > 9 (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous, independent of clk): s=0, c=0, out_valid=0, err=0. Hold while rst_n is low. First capture is on the first rising edge after rst_n deasserts.
- Latency is exactly 1 cycle. On a rising edge with in_valid=1, register the result of a, b, cin. Set out_valid=1 on the next cycle.
- On a rising edge with in_valid=0: out_valid=0; s, c, err hold their last values.
- Back-to-back in_valid is supported, giving one result per cycle with no stall and no backpressure.
- Per digit i (ripple, combinational within the cycle):
  - z = a_i + b_i + k_i, computed 5 bits wide, where k_0 = cin and k_i = carry of digit i-1.
  - carry_i = (z > 9).
  - s_i = (z + 6)[3:0] if carry_i, else z[3:0].
- c = carry of digit DIGITS-1.
- Non-BCD input digits (10..15) still follow the same rule with no saturation. Examples:
  - a=b=10: z=20 → s=4'b1010, c=1.
  - a=b=15: z=30 → s=4'b0100, c=1.
  - With cin=1, the maximum z is 31.
- err = OR over all digits of (a_i > 9 or b_i > 9). Registered with the same timing as s.
- If rst_n asserts mid-operation, any pending result is discarded and outputs go to their reset values immediately.

Optional Feature:
BCD_ADDER_ERR_EN
- Defined: err is computed as above.
- Undefined: err is constant 0 (port still present, no detection logic). Sum and carry behaviour is identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with prior nonzero outputs → s=0, c=0, out_valid=0, err=0 immediately, without waiting for a clock edge.
- Valid BCD sweep, DIGITS=1, cin=0, a=b=n for n=0..9 → s/c pairs as below, each one cycle after in_valid, with err=0:
  - n=0..4: s = 0, 2, 4, 6, 8; c=0.
  - n=5..9: s = 0, 2, 4, 6, 8; c=1.
- Invalid digits, DIGITS=1, a=b=n for n=10..15 → s/c pairs as below, with err=1 (ERR_EN defined):
  - s = 1010, 1100, 1110, 0000, 0010, 0100.
  - c=1 for all six.
- Carry-in: a=9, b=9, cin=1 → s=9, c=1. a=0, b=0, cin=1 → s=1, c=0.
- Ripple, DIGITS=4: a=16'h9999, b=16'h0001, cin=0 → s=16'h0000, c=1. a=16'h1234, b=16'h5678 → s=16'h6912, c=0.
- Handshake: in_valid pulses on cycles 1 and 2, low on cycle 3 → out_valid high on cycles 2 and 3, low on cycle 4; s holds the cycle-2 result during cycle 4.
